// File: rtl/qkv_psum_accum.sv
// Read-modify-write accumulator for QKV partial sums: adds each incoming token vector
// to the running sum in the value SRAM, saturating, and forwards final-pass sums.
module qkv_psum_accum #(
  parameter int IN_W   = 19,
  parameter int OUT_W  = 21,
  parameter int LANES  = 4,
  parameter int TOKENS = 729,
  parameter int PASSES = 16,
  parameter int ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic                   in_valid,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [LANES*OUT_W-1:0] rd_data,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [LANES*OUT_W-1:0] wr_data,
  output logic                   out_valid,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int TOK_W  = (TOKENS > 1) ? $clog2(TOKENS) : 1;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   base;
  logic [TOK_W-1:0]    tok;
  logic [PASS_W-1:0]   pass;
  logic                accept, tok_last, pass_last, start_ok, drain_done;

  logic                s1_valid, s1_first, s1_last;
  logic [LANES*IN_W-1:0] s1_data;
  logic [ADDR_W-1:0]   s1_addr;
  logic [LANES*OUT_W-1:0] sat_vec;

  assign accept    = in_valid && (state == RUN);
  assign start_ok  = start && (state == IDLE);
  assign tok_last  = (tok == TOK_W'(TOKENS - 1));
  assign pass_last = (pass == PASS_W'(PASSES - 1));
  assign rd_en     = accept && (pass != '0);
  assign rd_addr   = base + ADDR_W'(tok);
  assign busy      = (state != IDLE);
  assign out_data  = wr_data;
  // The last write is the one in flight once stage 1 has emptied in DRAIN.
  assign drain_done = (state == DRAIN) && wr_en && !s1_valid;

  always_comb begin
    // NOTE: next-state gets a default before the case so no path infers a latch.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept && tok_last && pass_last) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      base  <= '0;
      tok   <= '0;
      pass  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= drain_done;
      if (start_ok) begin
        base <= base_addr;
        tok  <= '0;
        pass <= '0;
      end else if (accept) begin
        if (tok_last) begin
          tok  <= '0;
          pass <= pass_last ? '0 : pass + 1'b1;
        end else begin
          tok <= tok + 1'b1;
        end
      end
      if (in_valid && state != RUN) err <= 1'b1;
      else if (start_ok)            err <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= accept;
  end

  // NOTE: stage-1 payload is qualified by s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_data  <= in_data;
      s1_addr  <= rd_addr;
      s1_first <= (pass == '0);
      s1_last  <= pass_last;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [OUT_W:0] in_ext, acc_ext, sum;
    assign in_ext  = {{(OUT_W + 1 - IN_W){s1_data[(i+1)*IN_W-1]}}, s1_data[i*IN_W +: IN_W]};
    assign acc_ext = s1_first ? '0 : {rd_data[(i+1)*OUT_W-1], rd_data[i*OUT_W +: OUT_W]};
    assign sum     = in_ext + acc_ext;
    // Overflow shows as disagreement between the guard bit and the OUT_W sign bit.
    assign sat_vec[i*OUT_W +: OUT_W] =
      (sum[OUT_W] != sum[OUT_W-1]) ?
        (sum[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}}) :
        sum[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en     <= 1'b0;
      out_valid <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_en     <= s1_valid;
      out_valid <= s1_valid && s1_last;
      if (s1_valid) begin
        wr_addr <= s1_addr;
        wr_data <= sat_vec;
      end
    end
  end

endmodule

// File: doc/qkv_psum_accum.md
# qkv_psum_accum

Read-modify-write accumulator that sits directly downstream of the QKV systolic PE blocks. Each pass delivers, per token, a vector of `LANES` signed partial sums for one 4-input-channel slice; the block adds each vector to the running sum held in the QKV value SRAM and writes the result back. Pass 0 initialises the SRAM. The final pass also forwards completed sums to the QK matmul stage.

## Interface
Parameters:
- `IN_W`, 19, signed width of one incoming partial sum (2*8 + 4 - 1).
- `OUT_W`, 21, signed width of a stored/accumulated sum.
- `LANES`, 4, partial sums per token vector (one SRAM row).
- `TOKENS`, 729, tokens per pass (27x27); must be >= 3.
- `PASSES`, 16, passes per job (64 input channels / 4).
- `ADDR_W`, 16, SRAM address width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  begin a job; sampled only in IDLE.
- `base_addr`  in  ADDR_W  SRAM base of the target region; latched on accepted `start`.
- `in_valid`  in  1  `in_data` holds the next token's vector.
- `in_data`  in  LANES*IN_W  lane i at bits [(i+1)*IN_W-1 : i*IN_W].
- `rd_en`  out  1  SRAM read request (combinational).
- `rd_addr`  out  ADDR_W  SRAM read address (combinational).
- `rd_data`  in  LANES*OUT_W  SRAM read data, valid one cycle after `rd_en`.
- `wr_en`  out  1  SRAM write strobe (registered).
- `wr_addr`  out  ADDR_W  SRAM write address (registered).
- `wr_data`  out  LANES*OUT_W  SRAM write data (registered).
- `out_valid`  out  1  final-pass sum vector valid (registered).
- `out_data`  out  LANES*OUT_W  equals `wr_data` when `out_valid`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse on job completion.
- `err`  out  1  sticky: `in_valid` seen outside RUN; cleared by reset or accepted `start`.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on `start`. This latches `base_addr` and clears the token counter `tok` and the pass counter `pass`.
  - RUN -> DRAIN when the vector with `tok == TOKENS-1` and `pass == PASSES-1` is accepted.
  - DRAIN -> IDLE once the final write has issued, pulsing `done`.
- `start` in RUN or DRAIN is ignored.
- Accept: `in_valid && state == RUN`.
  - On accept, `tok` increments.
  - At `TOKENS-1`, `tok` wraps to 0 and `pass` increments.
  - Gaps in `in_valid` are allowed; counters do not move without an accept.
  - There is no backpressure.
- Read: `rd_en = accept && pass != 0`; `rd_addr = base + tok`. Pass 0 never reads.
- Stage 1 registers: input vector, address, a first-pass flag, a last-pass flag, and a valid bit.
- Arithmetic, per lane:
  - Sign-extend `in` from IN_W to OUT_W+1 bits.
  - Pass 0: result = `sext(in)`.
  - Other passes: result = `sext(in) + rd_data_lane`, computed in OUT_W+1 bits.
  - Saturate the result to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Write: the stage-1 result drives `wr_*` on the next edge. `out_valid` asserts together with `wr_en` for last-pass vectors.
- Hazards: address k is reread at least `TOKENS` cycles after its previous read, while its write lands 2 cycles after that read. `TOKENS >= 3` therefore avoids read-during-write to the same address, and no forwarding is required.
- `in_valid` in IDLE or DRAIN: the data is dropped and `err` is set.

## Timing
- Reset values: `wr_en`, `out_valid`, `busy`, `done`, and `err` are 0; `wr_addr`, `wr_data`, and `out_data` are 0; state is IDLE.
- `reset` asserted mid-job: the job is aborted immediately with no further writes. A new `start` is required afterwards.
- Accept in cycle t:
  - `rd_en`/`rd_addr` are asserted in cycle t.
  - `rd_data` is consumed in t+1.
  - `wr_en`/`wr_data` (and `out_valid` on the last pass) are high in cycle t+2.
- Throughput: one vector per cycle, sustained across pass boundaries.
- Final accept at cycle t:
  - Last write at t+2.
  - `done` high at t+3.
  - `busy` low from t+3.
  - IDLE at t+3, so `start` is accepted in t+3.
- `busy` rises in the cycle after the accepted `start`.

## Test plan
- Single pass with `TOKENS=3`, `PASSES=1`, `base=0x10`:
  - Stimulus: vectors {1,2,3,4}, {-1,-2,-3,-4}, {0,0,0,0}.
  - Response: writes to 0x10–0x12 with the same values; `rd_en` never high; `out_valid` on all 3; `done` 1 cycle after the last write.
- Two passes with `TOKENS=3`, `PASSES=2`, a behavioural SRAM, each lane fed 100 then -30:
  - Response: final SRAM contents 70 in every lane.
  - Pass-1 reads hit 0x10–0x12; `out_valid` only in pass 1.
- Saturation with `OUT_W=21`, preloaded so that pass 0 writes 262143:
  - Add 262143 repeatedly over 8 passes; the lane clamps at 1048575.
  - With negative inputs, the lane clamps at -1048576.
- Bubbles:
  - `in_valid` toggling 1,0,0,1,... over 2 passes: addresses and sums are identical to the gapless run.
  - `done` timing is measured from the final accept.
- Control misuse:
  - `start` during RUN: ignored, and `base_addr` is unchanged.
  - `in_valid` in IDLE: `err`=1, no SRAM access.
  - A subsequent `start`: clears `err`.
- Reset mid-job at token 1 of pass 1:
  - All outputs go to 0 asynchronously, and no `wr_en` follows.
  - A restarted job then completes correctly.
